// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and system-bus constants for the instruction cache
// and the memory controller it talks to.
package cache_pkg;

    localparam int LINE_BITS     = 512;
    localparam int OFFSET_BITS   = 6;
    localparam int WORD_BITS     = 32;
    localparam int WORD_SEL_BITS = $clog2(LINE_BITS / WORD_BITS);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL_WAIT
    } icache_state_t;

    // Transaction tags the memory controller decodes on SYSBUS.
    localparam logic [3:0] SYSBUS_TAG_IFETCH = 4'h1;
    localparam logic [3:0] SYSBUS_TAG_DFETCH = 4'h2;
    localparam logic [3:0] SYSBUS_TAG_WRITE  = 4'h3;

endpackage

// File: rtl/icache_tag_array.sv
// Valid/tag/line storage for the direct-mapped instruction cache: one fill write
// port, one asynchronous read port and a synchronous clear of every valid bit.
module icache_tag_array
    import cache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int TAG_W = 52
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic [$clog2(SETS)-1:0] rd_index,
    output logic                    rd_valid,
    output logic [TAG_W-1:0]        rd_tag,
    output logic [LINE_BITS-1:0]    rd_line,
    input  logic                    wr_en,
    input  logic [$clog2(SETS)-1:0] wr_index,
    input  logic [TAG_W-1:0]        wr_tag,
    input  logic [LINE_BITS-1:0]    wr_line
);

    logic [SETS-1:0]      valid;
    logic [TAG_W-1:0]     tag_mem  [SETS];
    logic [LINE_BITS-1:0] line_mem [SETS];

    // Only the valid bits are cleared; tag and line contents are never used without them.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            line_mem[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = line_mem[rd_index];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: one outstanding fetch, hits answer in
// LOOKUP, misses fetch a whole line and forward the requested word as it arrives.
module icache_dm
    import cache_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [WORD_BITS-1:0]  resp_data,
    input  logic                  flush,
    output logic                  mem_start_req,
    output logic [63:0]           mem_addr,
    output logic                  mem_wr_en,
    input  logic [LINE_BITS-1:0]  mem_data_in,
    input  logic                  mem_data_valid
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS - IDX_W;

    icache_state_t             state;
    logic [ADDR_WIDTH-1:2]     addr_q;
    logic                      flush_pending;

    logic [IDX_W-1:0]          idx_q;
    logic [TAG_W-1:0]          tag_q;
    logic [WORD_SEL_BITS-1:0]  word_q;
    logic [ADDR_WIDTH-1:0]     line_addr;

    logic                      rd_valid;
    logic [TAG_W-1:0]          rd_tag;
    logic [LINE_BITS-1:0]      rd_line;
    logic                      hit;
    logic                      fill_state;
    logic                      fill_done;
    logic                      clear_all;
    logic                      unused_addr_bits;

    assign idx_q     = addr_q[OFFSET_BITS +: IDX_W];
    assign tag_q     = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign word_q    = addr_q[OFFSET_BITS-1:2];
    assign line_addr = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    assign unused_addr_bits = ^req_addr[1:0];

    assign hit        = rd_valid && (rd_tag == tag_q);
    assign fill_state = (state == FILL_REQ) || (state == FILL_WAIT);
    assign fill_done  = !rst && fill_state && mem_data_valid;
    assign clear_all  = rst || ((state == IDLE) && (flush || flush_pending));

    assign req_ready = (state == IDLE) && !flush && !flush_pending;
    assign mem_wr_en = 1'b0;

    icache_tag_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_tag_array (
        .clk      (clk),
        .clear    (clear_all),
        .rd_index (idx_q),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (fill_done),
        .wr_index (idx_q),
        .wr_tag   (tag_q),
        .wr_line  (mem_data_in)
    );

    // A returning line is forwarded directly so the miss answers in the data_valid cycle.
    always_comb begin
        resp_valid = 1'b0;
        resp_data  = '0;
        if (fill_done) begin
            resp_valid = 1'b1;
            resp_data  = mem_data_in[int'(word_q) * WORD_BITS +: WORD_BITS];
        end else if (!rst && (state == LOOKUP) && hit) begin
            resp_valid = 1'b1;
            resp_data  = rd_line[int'(word_q) * WORD_BITS +: WORD_BITS];
        end
    end

    // A flush seen mid-access is deferred so the access in flight still completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            flush_pending <= 1'b0;
            mem_start_req <= 1'b0;
            mem_addr      <= '0;
        end else begin
            if (state == IDLE) begin
                flush_pending <= 1'b0;
            end else if (flush) begin
                flush_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q <= req_addr[ADDR_WIDTH-1:2];
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        state <= IDLE;
                    end else begin
                        state         <= FILL_REQ;
                        mem_start_req <= 1'b1;
                        mem_addr      <= 64'(line_addr);
                    end
                end
                FILL_REQ, FILL_WAIT: begin
                    if (mem_data_valid) begin
                        state         <= IDLE;
                        mem_start_req <= 1'b0;
                        mem_addr      <= '0;
                    end else begin
                        state <= FILL_WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: a line-residency model predicts hits, fills and
// returned words while a compare process checks the DUT outputs every cycle.
module tb_icache_dm;

    localparam int SETS = 64;
    localparam int AW   = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [AW-1:0] req_addr;
    logic         req_ready;
    logic         resp_valid;
    logic [31:0]  resp_data;
    logic         flush;
    logic         mem_start_req;
    logic [63:0]  mem_addr;
    logic         mem_wr_en;
    logic [511:0] mem_data_in;
    logic         mem_data_valid;

    always #5 clk = ~clk;

    icache_dm #(.SETS(SETS), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .flush          (flush),
        .mem_start_req  (mem_start_req),
        .mem_addr       (mem_addr),
        .mem_wr_en      (mem_wr_en),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid)
    );

    int passed = 0;
    int total  = 0;
    bit checking = 1'b0;

    logic        exp_ready, exp_resp, exp_start;
    logic [31:0] exp_data;
    logic [63:0] exp_addr;

    // Model: which line number (addr >> 6) lives in each set, plus a deferred flush.
    bit              m_valid [SETS];
    longint unsigned m_line  [SETS];
    bit              m_pend;

    function automatic logic [31:0] memWord(input longint unsigned line, input int k);
        return 32'hA000_0000 + 32'(k) + (32'(line - 64) << 4);
    endfunction

    function automatic logic [511:0] makeLine(input longint unsigned line);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = memWord(line, k);
        return l;
    endfunction

    task automatic modelFlush();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("[TB] FAIL %s: got %h want %h at %0t", name, got, want, $time);
    endtask

    task automatic checkOutput();
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("resp_valid", 64'(resp_valid), 64'(exp_resp));
        if (exp_resp) check("resp_data", 64'(resp_data), 64'(exp_data));
        check("mem_start_req", 64'(mem_start_req), 64'(exp_start));
        if (exp_start) check("mem_addr", mem_addr, exp_addr);
        check("mem_wr_en", 64'(mem_wr_en), 64'd0);
    endtask

    always begin
        @(negedge clk);
        #2;
        if (checking) checkOutput();
    end

    task automatic nextCycle();
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; flush = 1'b0; mem_data_valid = 1'b0;
        req_addr = {$urandom, $urandom};
        mem_data_in = {16{$urandom}};
        exp_ready = 1'b0; exp_resp = 1'b0; exp_start = 1'b0;
        exp_data = '0; exp_addr = '0;
    endtask

    task automatic idleCycle(input bit fl, input bit req, input bit dv);
        nextCycle();
        flush = fl; req_valid = req; mem_data_valid = dv;
        exp_ready = !fl && !m_pend;
        if (fl || m_pend) modelFlush();
    endtask

    // One complete fetch; flush_at 0 = flush in LOOKUP, n>0 = flush in n-th fill cycle.
    task automatic applyStimulus(input logic [63:0] addr, input int lat, input int flush_at,
                                 output bit saw_start, output logic [31:0] got_data,
                                 output logic [63:0] got_addr);
        longint unsigned line = addr >> 6;
        int idx  = int'(line % SETS);
        int word = int'((addr >> 2) & 64'd15);
        bit hit;
        saw_start = 1'b0; got_data = '0; got_addr = '0;
        if (m_pend) begin
            nextCycle();
            req_valid = 1'b1; req_addr = addr;
            modelFlush();
        end
        nextCycle();
        req_valid = 1'b1; req_addr = addr; exp_ready = 1'b1;
        hit = m_valid[idx] && (m_line[idx] == line);
        nextCycle();
        if (flush_at == 0) begin flush = 1'b1; m_pend = 1'b1; end
        if (hit) begin
            exp_resp = 1'b1; exp_data = memWord(line, word);
            #3 got_data = resp_data;
            return;
        end
        for (int i = 0; i <= lat; i++) begin
            nextCycle();
            exp_start = 1'b1; exp_addr = {addr[63:6], 6'b0};
            if (flush_at == i + 1) begin flush = 1'b1; m_pend = 1'b1; end
            if (i == lat) begin
                mem_data_valid = 1'b1; mem_data_in = makeLine(line);
                exp_resp = 1'b1; exp_data = memWord(line, word);
                m_valid[idx] = 1'b1; m_line[idx] = line;
            end
            #3;
            if (i == 0) begin saw_start = mem_start_req; got_addr = mem_addr; end
            if (i == lat) got_data = resp_data;
        end
    endtask

    initial begin
        bit          s;
        logic [31:0] d;
        logic [63:0] a;
        int          lat, fa, r;
        logic [63:0] ra;

        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; mem_data_valid = 1'b0;
        req_addr = '0; mem_data_in = '0;
        modelFlush();
        repeat (3) @(negedge clk);

        nextCycle();
        exp_ready = 1'b1; checking = 1'b1;
        #3;
        check("reset_resp_data", 64'(resp_data), 64'd0);
        check("reset_mem_addr", mem_addr, 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd1);

        applyStimulus(64'h1000, 5, -1, s, d, a);
        check("cold_miss_start", 64'(s), 64'd1);
        check("cold_fill_addr", a, 64'h1000);
        check("cold_resp_word0", 64'(d), 64'hA000_0000);

        applyStimulus(64'h1008, 2, -1, s, d, a);
        check("hit_word2", 64'(d), 64'hA000_0002);

        applyStimulus(64'h2000, 3, 2, s, d, a);
        check("conflict_miss_start", 64'(s), 64'd1);
        check("conflict_resp", 64'(d), 64'hA000_0400);
        idleCycle(1'b0, 1'b0, 1'b0);
        idleCycle(1'b0, 1'b0, 1'b0);

        applyStimulus(64'h2000, 1, -1, s, d, a);
        check("post_flush_miss", 64'(s), 64'd1);
        applyStimulus(64'h1000, 0, -1, s, d, a);
        check("refill_1000_miss", 64'(s), 64'd1);
        check("refill_1000_resp", 64'(d), 64'hA000_0000);
        applyStimulus(64'h103C, 1, -1, s, d, a);
        check("hit_word15", 64'(d), 64'hA000_000F);

        // Reset while the fill is outstanding, then a stray data_valid.
        nextCycle(); req_valid = 1'b1; req_addr = 64'h3040; exp_ready = 1'b1;
        nextCycle();
        nextCycle(); exp_start = 1'b1; exp_addr = 64'h3040;
        nextCycle(); exp_start = 1'b1; exp_addr = 64'h3040; rst = 1'b1;
        modelFlush();
        nextCycle(); mem_data_valid = 1'b1; mem_data_in = makeLine(64'h3040 >> 6); exp_ready = 1'b1;
        #3 check("stray_dv_no_resp", 64'(resp_valid), 64'd0);
        applyStimulus(64'h3040, 2, -1, s, d, a);
        check("post_reset_miss", 64'(s), 64'd1);

        // Flush and a request in the same idle cycle.
        applyStimulus(64'h1000, 1, -1, s, d, a);
        idleCycle(1'b1, 1'b1, 1'b0);
        applyStimulus(64'h1000, 1, -1, s, d, a);
        check("flush_req_same_cycle_miss", 64'(s), 64'd1);

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                idleCycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            end else if (r == 1) begin
                idleCycle(1'b0, 1'b0, 1'b1);
            end else if (r == 2) begin
                idleCycle(1'b0, 1'b0, 1'b0);
            end else begin
                ra  = (64'($urandom_range(0, 15)) << 12) | (64'($urandom_range(0, 3)) << 6)
                    | 64'($urandom_range(0, 63));
                lat = int'($urandom_range(0, 4));
                fa  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, lat + 1)) : -1;
                applyStimulus(ra, lat, fa, s, d, a);
            end
        end

        checking = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
